// File: rtl/lime_io_sequencer.sv
// Table-driven stimulus/checker sequencer for the TheLime main_input/main_output pair.
// Applies each stimulus, waits for the expected answer and records cycles taken per test.
module lime_io_sequencer #(
   parameter int WIDTH     = 16,
   parameter int NUM_TESTS = 3,
   parameter int IDX_W     = 2,
   parameter int CNT_WIDTH = 32,
   parameter int TIMEOUT   = 1000000,
   parameter int SETTLE    = 2
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_addr,
   input  logic [WIDTH-1:0]     cfg_stim,
   input  logic [WIDTH-1:0]     cfg_expect,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dut_output,
   output logic [WIDTH-1:0]     dut_input,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [IDX_W-1:0]     cur_index,
   output logic [IDX_W-1:0]     fail_index,
   input  logic [IDX_W-1:0]     rd_addr,
   output logic [CNT_WIDTH-1:0] rd_cycles
);

   localparam int                   DEPTH    = 1 << IDX_W;
   localparam logic [CNT_WIDTH-1:0] TO_C     = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] SETTLE_C = CNT_WIDTH'(SETTLE);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TESTS - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_PASS, S_FAIL} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     din_q, din_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pass_q, pass_d;
   logic [IDX_W-1:0]     cur_q, cur_d;
   logic [IDX_W-1:0]     fail_q, fail_d;
   logic [CNT_WIDTH-1:0] rdc_q, rdc_d;
   logic [WIDTH-1:0]     stim_q [DEPTH];
   logic [WIDTH-1:0]     stim_d [DEPTH];
   logic [WIDTH-1:0]     exp_q  [DEPTH];
   logic [WIDTH-1:0]     exp_d  [DEPTH];
   logic [CNT_WIDTH-1:0] res_q  [DEPTH];
   logic [CNT_WIDTH-1:0] res_d  [DEPTH];

   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic [IDX_W-1:0]     idx_nxt;
   logic                 match;

   assign cnt_nxt = cnt_q + CNT_WIDTH'(1);
   assign idx_nxt = idx_q + IDX_W'(1);
   assign match   = (cnt_q >= SETTLE_C) && (dut_output == exp_q[idx_q]);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      cur_d   = cur_q;
      fail_d  = fail_q;
      stim_d  = stim_q;
      exp_d   = exp_q;
      res_d   = res_q;
      rdc_d   = res_q[rd_addr];

      // Table write precedes start so a same-edge write is seen by LOAD.
      if (state_q == S_IDLE || state_q == S_PASS || state_q == S_FAIL) begin
         if (cfg_we && (32'(cfg_addr) < NUM_TESTS)) begin
            stim_d[cfg_addr] = cfg_stim;
            exp_d[cfg_addr]  = cfg_expect;
         end
         if (start) begin
            for (int i = 0; i < DEPTH; i++) res_d[i] = '0;
            idx_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            state_d = S_LOAD;
         end
      end

      case (state_q)
         S_LOAD: begin
            din_d   = stim_q[idx_q];
            cnt_d   = '0;
            busy_d  = 1'b1;
            cur_d   = idx_q;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (match) begin
               res_d[idx_q] = cnt_nxt;
               if (idx_q == LAST_IDX) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = 1'b1;
                  state_d = S_PASS;
               end else begin
                  idx_d = idx_nxt;
                  cur_d = idx_nxt;
                  din_d = stim_q[idx_nxt];
                  cnt_d = '0;
               end
            end else if (cnt_nxt == TO_C) begin
               res_d[idx_q] = TO_C;
               fail_d  = idx_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = 1'b0;
               state_d = S_FAIL;
            end else begin
               cnt_d = cnt_nxt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         cur_q   <= '0;
         fail_q  <= '0;
         rdc_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stim_q[i] <= '0;
            exp_q[i]  <= '0;
            res_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         cur_q   <= cur_d;
         fail_q  <= fail_d;
         rdc_q   <= rdc_d;
         stim_q  <= stim_d;
         exp_q   <= exp_d;
         res_q   <= res_d;
      end
   end

   assign dut_input  = din_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign cur_index  = cur_q;
   assign fail_index = fail_q;
   assign rd_cycles  = rdc_q;

endmodule

// File: tb/tb_lime_io_sequencer.sv
// Scoreboard bench for lime_io_sequencer: a delayed-response processor model answers
// each stimulus; expected stimuli and cycle counts are queued at start and popped as the DUT reports.
module tb_lime_io_sequencer;

   localparam int W  = 16;
   localparam int IW = 2;
   localparam int CW = 32;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          cfg_we;
   logic [IW-1:0] cfg_addr;
   logic [W-1:0]  cfg_stim, cfg_expect;
   logic          start;
   logic [W-1:0]  dut_output = '0;
   logic [W-1:0]  dut_input;
   logic          busy, done, pass;
   logic [IW-1:0] cur_index, fail_index, rd_addr;
   logic [CW-1:0] rd_cycles;

   logic          d1_we, d1_start;
   logic [IW-1:0] d1_addr, d1_rd, d1_cur, d1_fail;
   logic [7:0]    d1_stim, d1_exp, d1_out, d1_in;
   logic          d1_busy, d1_done, d1_pass;
   logic [CW-1:0] d1_cyc;

   always #5 CLK = ~CLK;

   lime_io_sequencer #(.WIDTH(W), .NUM_TESTS(3), .IDX_W(IW), .CNT_WIDTH(CW),
                       .TIMEOUT(50), .SETTLE(2)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_stim(cfg_stim), .cfg_expect(cfg_expect), .start(start),
      .dut_output(dut_output), .dut_input(dut_input), .busy(busy), .done(done),
      .pass(pass), .cur_index(cur_index), .fail_index(fail_index),
      .rd_addr(rd_addr), .rd_cycles(rd_cycles));

   lime_io_sequencer #(.WIDTH(8), .NUM_TESTS(1), .IDX_W(IW), .CNT_WIDTH(CW),
                       .TIMEOUT(50), .SETTLE(2)) u_dut1 (
      .CLK(CLK), .RST_N(RST_N), .cfg_we(d1_we), .cfg_addr(d1_addr),
      .cfg_stim(d1_stim), .cfg_expect(d1_exp), .start(d1_start),
      .dut_output(d1_out), .dut_input(d1_in), .busy(d1_busy), .done(d1_done),
      .pass(d1_pass), .cur_index(d1_cur), .fail_index(d1_fail),
      .rd_addr(d1_rd), .rd_cycles(d1_cyc));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Processor model: answers tbl_exp[i] once stim tbl_stim[i] has been applied for tbl_dly[i]
   // cycles (0 = never). A new stimulus or run start blanks the output unless m_hold is set.
   logic [W-1:0] tbl_stim [3];
   logic [W-1:0] tbl_exp  [3];
   int           tbl_dly  [3];
   bit           m_hold = 1'b0;
   int           m_age  = 0;
   logic [W-1:0] m_last = '0;
   logic         m_pb   = 1'b0;

   always @(negedge CLK) begin
      if ((busy && !m_pb) || (dut_input != m_last)) begin
         m_age = 0;
         if (!m_hold) dut_output = '0;
      end else if (m_age < 100000) begin
         m_age++;
      end
      m_pb   = busy;
      m_last = dut_input;
      for (int i = 0; i < 3; i++)
         if (tbl_stim[i] == dut_input && tbl_dly[i] != 0 && m_age >= tbl_dly[i] - 1)
            dut_output = tbl_exp[i];
   end

   logic [W-1:0] q_stim [$];
   int           q_cyc  [$];

   task automatic write_tbl(input int i, input logic [W-1:0] s, input logic [W-1:0] e, input int d);
      cfg_we = 1'b1; cfg_addr = IW'(i); cfg_stim = s; cfg_expect = e;
      tbl_stim[i] = s; tbl_exp[i] = e; tbl_dly[i] = d;
      @(negedge CLK);
      cfg_we = 1'b0;
   endtask

   task automatic run(input bit ep, input int efi, input int c0, input int c1, input int c2,
                      input bit poke);
      int   nap;
      bit   fin, poked;
      logic pb;
      logic [IW-1:0] pc;
      nap = ep ? 3 : efi + 1;
      for (int i = 0; i < nap; i++) q_stim.push_back(tbl_stim[i]);
      q_cyc.push_back(c0); q_cyc.push_back(c1); q_cyc.push_back(c2);
      pb = busy; pc = cur_index; fin = 1'b0; poked = 1'b0;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      for (int c = 0; c < 3000 && !fin; c++) begin
         @(negedge CLK);
         cfg_we = 1'b0; start = 1'b0;
         if (poke && !poked && busy && cur_index == 2'd1) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_stim = 16'h7777; cfg_expect = 16'h7777;
            start = 1'b1; poked = 1'b1;
         end
         if ((busy && !pb) || (busy && cur_index != pc)) begin
            if (q_stim.size() > 0) chk("stim", 64'(dut_input), 64'(q_stim.pop_front()));
            else chk("extra_stim", 64'(dut_input), 64'hDEAD);
         end
         pb = busy; pc = cur_index;
         if (done) fin = 1'b1;
      end
      cfg_we = 1'b0; start = 1'b0;
      chk("run_done", 64'(fin), 64'd1);
      chk("pass", 64'(pass), 64'(ep));
      chk("busy_end", 64'(busy), 64'd0);
      chk("cur_index", 64'(cur_index), ep ? 64'd2 : 64'(efi));
      if (!ep) chk("fail_index", 64'(fail_index), 64'(efi));
      chk("stim_left", 64'(q_stim.size()), 64'd0);
      q_stim.delete();
      for (int i = 0; i < 3; i++) begin
         rd_addr = IW'(i);
         @(negedge CLK);
         chk($sformatf("cycles[%0d]", i), 64'(rd_cycles), 64'(q_cyc.pop_front()));
      end
   endtask

   task automatic basic_table();
      write_tbl(0, 16'd30,    16'd5,     20);
      write_tbl(1, 16'h0906,  16'h000D,  40);
      write_tbl(2, 16'd30,    16'd5,     20);
   endtask

   initial begin
      bit hit;
      RST_N = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_stim = '0; cfg_expect = '0;
      start = 1'b0; rd_addr = '0;
      d1_we = 1'b0; d1_start = 1'b0; d1_addr = '0; d1_rd = '0;
      d1_stim = '0; d1_exp = '0; d1_out = '0;
      for (int i = 0; i < 3; i++) begin tbl_stim[i] = '0; tbl_exp[i] = '0; tbl_dly[i] = 0; end
      repeat (3) @(negedge CLK);
      chk("rst_din",  64'(dut_input), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_cur",  64'(cur_index), 64'd0);
      chk("rst_fail", 64'(fail_index), 64'd0);
      chk("rst_rdc",  64'(rd_cycles), 64'd0);
      RST_N = 1'b1;
      @(negedge CLK);

      basic_table();
      run(1'b1, 0, 20, 40, 20, 1'b1);
      run(1'b1, 0, 20, 40, 20, 1'b0);

      m_hold = 1'b1;
      write_tbl(0, 16'h0100, 16'd5,    0);
      write_tbl(1, 16'h0200, 16'h00AA, 7);
      write_tbl(2, 16'h0300, 16'h00BB, 9);
      run(1'b1, 0, 3, 7, 9, 1'b0);
      m_hold = 1'b0;

      write_tbl(0, 16'h0011, 16'h0021, 10);
      write_tbl(1, 16'h0012, 16'h0022, 0);
      write_tbl(2, 16'h0013, 16'h0023, 15);
      run(1'b0, 1, 10, 50, 0, 1'b0);

      basic_table();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 500 && !hit; c++) begin
         @(negedge CLK);
         if (busy && cur_index == 2'd1) hit = 1'b1;
      end
      chk("reach_test1", 64'(hit), 64'd1);
      repeat (5) @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("mrst_din",  64'(dut_input), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_pass", 64'(pass), 64'd0);
      chk("mrst_cur",  64'(cur_index), 64'd0);
      chk("mrst_fail", 64'(fail_index), 64'd0);
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tbl_stim[i] = '0; tbl_exp[i] = '0; tbl_dly[i] = 0;
         rd_addr = IW'(i);
         @(negedge CLK);
         chk($sformatf("mrst_res[%0d]", i), 64'(rd_cycles), 64'd0);
      end
      run(1'b1, 0, 3, 3, 3, 1'b0);

      d1_we = 1'b1; d1_addr = 2'd0; d1_stim = 8'h11; d1_exp = 8'h22;
      @(negedge CLK);
      d1_addr = 2'd2; d1_stim = 8'h33; d1_exp = 8'h44;
      @(negedge CLK);
      d1_we = 1'b0; d1_out = 8'h22; d1_start = 1'b1;
      @(negedge CLK);
      d1_start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge CLK);
         if (d1_done) hit = 1'b1;
      end
      chk("d1_done", 64'(hit), 64'd1);
      chk("d1_pass", 64'(d1_pass), 64'd1);
      chk("d1_din",  64'(d1_in), 64'h11);
      chk("d1_cur",  64'(d1_cur), 64'd0);
      d1_rd = 2'd0;
      @(negedge CLK);
      chk("d1_cycles", 64'(d1_cyc), 64'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lime_io_sequencer.md
Name: lime_io_sequencer

Overview:
- Synthesizable, parametrised stimulus/checker sequencer for the TheLime processor's main_input/main_output pair.
- Holds a table of NUM_TESTS (stimulus, expected-output) pairs and drives each stimulus onto the processor input in turn.
- Waits for the expected output, records the cycles taken per test, and reports pass, or fail with a timeout.
- Used for on-board self-test and for benchmarking relprime-style programs without a simulator.

Parameters:
- WIDTH, 16, data width of stimulus, expected value and DUT ports
- NUM_TESTS, 3, number of table entries used per run (1..2^IDX_W)
- IDX_W, 2, width of table index/address
- CNT_WIDTH, 32, width of per-test cycle counters
- TIMEOUT, 1000000, max WAIT cycles per test before failure (< 2^CNT_WIDTH)
- SETTLE, 2, WAIT cycles after a new stimulus during which matches are ignored

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous active-low reset
- cfg_we  in  1  write table entry at cfg_addr (ignored while busy)
- cfg_addr  in  IDX_W  table write address
- cfg_stim  in  WIDTH  stimulus value to write
- cfg_expect  in  WIDTH  expected output value to write
- start  in  1  begin run (ignored while busy)
- dut_output  in  WIDTH  processor main_output
- dut_input  out  WIDTH  processor main_input
- busy  out  1  run in progress
- done  out  1  run finished, held until next start or reset
- pass  out  1  valid when done: 1 = all tests matched
- cur_index  out  IDX_W  test currently executing / last executed
- fail_index  out  IDX_W  test that timed out (valid when done & ~pass)
- rd_addr  in  IDX_W  result read address
- rd_cycles  out  CNT_WIDTH  recorded cycle count of entry rd_addr, 1-cycle registered latency

Behaviour:
- Interface: one clock, CLK; synchronous active-low reset, RST_N.
- Reset (RST_N=0 at an edge):
  - Clears all outputs to 0, all table entries (stim, expect), all result counters, and internal counters; state goes to IDLE.
  - Reset mid-run aborts immediately; no partial results are kept.
- States: IDLE, LOAD, WAIT, PASS, FAIL.
- IDLE / PASS / FAIL:
  - cfg_we writes stim[cfg_addr] and expect[cfg_addr]; addresses >= NUM_TESTS are ignored.
  - start=1 goes to LOAD. On that same edge: clear all result counters, idx <= 0, done <= 0, pass <= 0.
  - cfg_we and start together on one edge: the write happens first, so the run uses the new value.
- LOAD (one cycle):
  - dut_input <= stim[idx], cnt <= 0, busy <= 1, cur_index <= idx; go to WAIT.
- WAIT, each cycle: cnt_next = cnt + 1.
  - Match: cnt >= SETTLE and dut_output == expect[idx].
    - result[idx] <= cnt_next.
    - If idx == NUM_TESTS-1: go to PASS, busy <= 0, done <= 1, pass <= 1. dut_input holds its last value.
    - Else: idx <= idx+1, cur_index <= idx+1, dut_input <= stim[idx+1], cnt <= 0, stay in WAIT. This is a back-to-back switch with no LOAD bubble.
  - No match and cnt_next == TIMEOUT: go to FAIL, busy <= 0, done <= 1, pass <= 0, fail_index <= idx, result[idx] <= TIMEOUT.
  - Otherwise: cnt <= cnt_next.
  - Match and timeout in the same cycle: match wins.
- Counting: cycles are counted from the first WAIT cycle of a test up to and including the match cycle. The minimum recorded value is SETTLE+1.
- Counters never wrap, because TIMEOUT bounds them.
- rd_cycles <= result[rd_addr] every cycle, including during a run. Reading entries not yet reached returns 0.
- Comparison is full-width and unsigned-equality only.

Test Plan:
- Basic pass: table {30→5, 0x0906→0x000D, 30→5}; the bench DUT model returns the expected value 20, 40 and 20 cycles after each input change. Start → dut_input steps 30, 0x0906, 30; done=1, pass=1; rd_cycles = 20, 40, 20 (±1 per the counting rule checked exactly).
- Timeout: TIMEOUT=50, the model never answers test 1 → FAIL at cycle 50 of test 1; fail_index=1, pass=0, result[1]=50, result[2]=0.
- Settle filter: expect[0] equals the stale dut_output already present at start → the match is ignored for SETTLE cycles and accepted at cnt=SETTLE; recorded count = SETTLE+1.
- Reset mid-run: assert RST_N=0 during test 1 WAIT → next cycle all outputs are 0, state is IDLE, and table and results are cleared.
- Config lockout / restart: cfg_we while busy leaves the table unchanged. A second start after PASS clears results and reruns with identical counts. start while busy is ignored.
- Edge config: NUM_TESTS=1, WIDTH=8 → a single test passes. A write to cfg_addr=2 is ignored.
